// File: rtl/rle_decomp_ctrl_if.sv
// Compressed-memory read port and pixel-write handshake shared by the
// RLE sequencer (master) and the memory / image buffer side (slave).
interface rle_decomp_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int PIX_W  = 14
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_addr;
    logic              pix_bit;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output pix_valid,
        output pix_addr,
        output pix_bit,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  pix_valid,
        input  pix_addr,
        input  pix_bit,
        output pix_ready
    );
endinterface

// File: rtl/rle_decomp_ctrl.sv
// Run-length decompression sequencer: fetches 16-bit RLE words and
// expands each run into pixel writes toward the image buffer.
module rle_decomp_ctrl #(
    parameter int NUM_WORDS    = 1631,
    parameter int TOTAL_PIXELS = 16384,
    parameter int ADDR_W       = 11,
    parameter int PIX_W        = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    rle_decomp_ctrl_if.master bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_short_o,
    output logic              err_long_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [PIX_W:0]    TOTAL_C     = (PIX_W+1)'(TOTAL_PIXELS);
    localparam logic [PIX_W:0]    ONE_PIX     = (PIX_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_WORD_C = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE_WORD    = ADDR_W'(1);
    localparam logic [14:0]       ONE_RUN     = 15'd1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [PIX_W:0]    pix_cnt_q, pix_cnt_d;
    logic [14:0]       run_left_q, run_left_d;
    logic              run_bit_q, run_bit_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;

    logic           last_word;
    logic [PIX_W:0] pix_inc;

    assign last_word = (word_idx_q == LAST_WORD_C);
    assign pix_inc   = pix_cnt_q + ONE_PIX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            pix_cnt_q   <= '0;
            run_left_q  <= '0;
            run_bit_q   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            run_left_q  <= run_left_d;
            run_bit_q   <= run_bit_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        pix_cnt_d   = pix_cnt_q;
        run_left_d  = run_left_q;
        run_bit_d   = run_bit_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_FETCH;
                    word_idx_d  = '0;
                    pix_cnt_d   = '0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                run_bit_d  = bus.mem_rdata[15];
                run_left_d = bus.mem_rdata[14:0];
                if (bus.mem_rdata[14:0] != '0) begin
                    state_d = S_EMIT;
                end else if (last_word) begin
                    state_d     = S_DONE;
                    err_short_d = (pix_cnt_q < TOTAL_C);
                end else begin
                    state_d    = S_FETCH;
                    word_idx_d = word_idx_q + ONE_WORD;
                end
            end
            S_EMIT: begin
                if (bus.pix_ready) begin
                    pix_cnt_d  = pix_inc;
                    run_left_d = run_left_q - ONE_RUN;
                    // Image full: anything left in the run or stream is excess
                    if (pix_inc == TOTAL_C) begin
                        state_d    = S_DONE;
                        err_long_d = (run_left_q != ONE_RUN) || !last_word;
                    end else if (run_left_q == ONE_RUN) begin
                        if (last_word) begin
                            state_d     = S_DONE;
                            err_short_d = (pix_inc < TOTAL_C);
                        end else begin
                            state_d    = S_FETCH;
                            word_idx_d = word_idx_q + ONE_WORD;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_rd_en = (state_q == S_FETCH);
        bus.mem_addr  = (state_q == S_FETCH) ? word_idx_q : '0;
        bus.pix_valid = (state_q == S_EMIT);
        bus.pix_addr  = (state_q == S_EMIT) ? pix_cnt_q[PIX_W-1:0] : '0;
        bus.pix_bit   = (state_q == S_EMIT) ? run_bit_q : 1'b0;
    end

    assign busy_o      = (state_q == S_FETCH) || (state_q == S_WAIT)
                      || (state_q == S_EMIT);
    assign done_o      = (state_q == S_DONE);
    assign err_short_o = err_short_q;
    assign err_long_o  = err_long_q;

endmodule

// File: doc/rle_decomp_ctrl.md
Name: rle_decomp_ctrl

Overview:
- Sequencer for run-length image decompression.
- Fetches 16-bit RLE words from the compressed-data memory: bit[15] is the pixel value, bits[14:0] are the run count.
- Expands each run into one pixel write per accepted handshake toward the image buffer, which feeds the CNN input stage.
- Tracks word and pixel indices, stalls on back-pressure, and flags streams whose total length is short or long.

Parameters:
- NUM_WORDS, 1631, number of RLE words in the compressed memory.
- TOTAL_PIXELS, 16384, number of pixels in one decompressed image (128x128).
- ADDR_W, 11, width of the compressed-memory address; must satisfy 2^ADDR_W >= NUM_WORDS.
- PIX_W, 14, width of the pixel address; must satisfy 2^PIX_W >= TOTAL_PIXELS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse that begins decompression of one image.
- mem_rd_en, output, 1, read strobe to the compressed memory.
- mem_addr, output, ADDR_W, word address for the read.
- mem_rdata, input, 16, read data; valid exactly 1 cycle after mem_rd_en.
- pix_valid, output, 1, pixel write request.
- pix_ready, input, 1, image buffer accepts the write.
- pix_addr, output, PIX_W, linear pixel index; 0 is the first pixel.
- pix_bit, output, 1, pixel value.
- busy, output, 1, high from FETCH through the last EMIT.
- done, output, 1, level; high in DONE, cleared by the next start.
- err_short, output, 1, word stream ended before TOTAL_PIXELS pixels were written.
- err_long, output, 1, TOTAL_PIXELS reached while run or word data remained.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous, active-high. It forces state IDLE and clears every output and counter: mem_rd_en, mem_addr, pix_valid, pix_addr, pix_bit, busy, done, err_short, err_long are all 0.
  - rst mid-operation abandons the image with no further writes. The image buffer contents are undefined.
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE: waits for start.
  - start=1 → FETCH; word_idx=0, pix_cnt=0, done/err cleared, busy=1.
- FETCH: mem_rd_en=1 and mem_addr=word_idx for exactly one cycle → WAIT.
- WAIT: capture run_bit=mem_rdata[15] and run_left=mem_rdata[14:0].
  - If count≠0 → EMIT.
  - If count=0, the word is skipped:
    - word_idx==NUM_WORDS-1 → DONE.
    - otherwise word_idx+1 → FETCH.
- EMIT: pix_valid=1, pix_bit=run_bit, pix_addr=pix_cnt.
  - Outputs hold stable while pix_ready=0.
  - On pix_valid&pix_ready: pix_cnt+1, run_left-1.
  - After the last pixel of a run (run_left was 1):
    - If pix_cnt+1==TOTAL_PIXELS → DONE; set err_long if word_idx<NUM_WORDS-1.
    - Else if word_idx==NUM_WORDS-1 → DONE.
    - Else word_idx+1 → FETCH.
  - If pix_cnt+1==TOTAL_PIXELS while run_left>1 → DONE with err_long=1. No write beyond TOTAL_PIXELS-1 is ever issued.
- DONE: busy=0, done=1.
  - err_short=1 if pix_cnt<TOTAL_PIXELS on entry.
  - start → FETCH of a new image, clearing done and the error flags.
- start while busy is ignored.
- Latency:
  - start sampled at edge n → mem_rd_en high in cycle n+1 → first pix_valid in cycle n+3.
  - Each subsequent run costs 2 cycles of fetch overhead.
  - Pixel throughput is 1 per cycle while pix_ready=1.
- Counters:
  - pix_cnt is PIX_W+1 bits so TOTAL_PIXELS=2^PIX_W is representable.
  - run_left is 15 bits; the maximum run of 32767 is legal.
  - Counters do not wrap.

Test Plan:
- Use NUM_WORDS=3, TOTAL_PIXELS=8, pix_ready=1. Memory {0x8003, 0x0004, 0x8001}. start → mem_rd_en in cycle 1 at addr 0; first pix_valid in cycle 3. Writes are addr0-2 bit1, addr3-6 bit0, addr7 bit1; then done=1, err_short=0, err_long=0.
- Same memory, pix_ready toggling 1,0,1,0. Every write still occurs exactly once, in order, with pix_addr/pix_bit stable during stall cycles; final pix_cnt is 8.
- Memory {0x0000, 0x8005, 0x0003}, TOTAL_PIXELS=8. The zero-count word is skipped with no write. Writes are addr0-4=1, addr5-7=0; done=1 with no errors.
- Memory {0x8002, 0x0002, 0x8001}, TOTAL_PIXELS=8. After 5 writes: done=1, err_short=1, err_long=0.
- Memory {0x800A, …}, TOTAL_PIXELS=8. Exactly 8 writes (addr0-7, bit1), then done=1, err_long=1; addr 8 is never written.
- Assert rst during EMIT at pix_addr 4. All outputs go to 0 asynchronously and the state is IDLE. A following start restarts at addr 0 and produces the full correct sequence.
